// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;
    localparam bcd_digit_t BCD_SIX  = 4'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // True when a 4-bit code is not a legal decimal digit.
    function automatic logic is_non_bcd(input bcd_digit_t d);
        return (d > BCD_NINE);
    endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single BCD digit add/subtract cell.
// Subtraction uses the 9's complement of b plus an incoming carry of 1
// (10's complement overall). A raw sum above nine is corrected by +6 and
// produces a decimal carry.
import bcd_pkg::*;

module bcd_digit_addsub (
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       sub,
    input  logic       cin,
    output bcd_digit_t digit,
    output logic       cout
);

    bcd_digit_t b_eff;
    logic [4:0] raw;

    // Select b or its 9's complement, add, then apply the decimal correction.
    always_comb begin
        b_eff = sub ? (BCD_NINE - b) : b;
        raw   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
        digit = raw[3:0];
        cout  = 1'b0;
        if (raw > 5'd9) begin
            digit = raw[3:0] + BCD_SIX;
            cout  = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional feature macro: BCD_INPUT_CHECK_EN (adds bcd_err output and the
// per-digit legality check of a and b at acceptance).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE, and
// result/cout (and bcd_err) stay stable while out_valid is high and
// out_ready is low. Neither valid depends combinationally on its ready.
import bcd_pkg::*;

module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  sub,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output state_t                dbg_state,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout
`ifdef BCD_INPUT_CHECK_EN
    ,
    output logic                  bcd_err
`endif
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  res_sr;
    logic [W+3:0]  res_cat;
    logic          sub_q;
    logic          carry_q;
    logic          cout_q;
    bcd_digit_t    dig;
    logic          dig_cout;
    logic          accept;
    logic          last_digit;

    assign accept     = (state == S_IDLE) && in_valid;
    assign last_digit = (cnt == LAST_DIGIT);

    // Low digit of the operand shift registers through the one-digit cell.
    bcd_digit_addsub u_digit (
        .a     (a_sr[3:0]),
        .b     (b_sr[3:0]),
        .sub   (sub_q),
        .cin   (carry_q),
        .digit (dig),
        .cout  (dig_cout)
    );

    // New digit enters at the top; after DIGITS shifts digit 0 sits at the bottom.
    assign res_cat = {dig, res_sr} >> 4;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = S_RUN;
            end
            S_RUN: begin
                if (last_digit) state_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, per-digit shifting, counter and final carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= b;
            sub_q   <= sub;
            carry_q <= sub ? 1'b1 : cin;
            cnt     <= '0;
        end else if (state == S_RUN) begin
            a_sr    <= a_sr >> 4;
            b_sr    <= b_sr >> 4;
            res_sr  <= res_cat[W-1:0];
            carry_q <= dig_cout;
            cnt     <= cnt + 1'b1;
            if (last_digit) cout_q <= dig_cout;
        end
    end

    assign result    = res_sr;
    assign cout      = cout_q;
    assign dbg_state = state;

`ifdef BCD_INPUT_CHECK_EN
    logic in_err;
    logic err_q;

    // Flag any non-decimal digit in either incoming operand.
    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (is_non_bcd(a[4*i +: 4]) || is_non_bcd(b[4*i +: 4])) in_err = 1'b1;
        end
    end

    // Error flag: captured at acceptance, held through DONE, cleared on result handshake.
    always_ff @(posedge clk) begin
        if (!rst_n)                              err_q <= 1'b0;
        else if (accept)                         err_q <= in_err;
        else if ((state == S_DONE) && out_ready) err_q <= 1'b0;
    end

    assign bcd_err = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4 main instance plus a
// DIGITS=1 instance). Expected values come from integer decimal arithmetic.
import bcd_pkg::*;

module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MOD    = 10 ** DIGITS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DIGITS=4 instance ----------------
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          sub = 1'b0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    state_t        dbg_state;
    logic [W-1:0]  result;
    logic          cout;
`ifdef BCD_INPUT_CHECK_EN
    logic          bcd_err;
`endif

    bcd_serial_addsub #(.DIGITS(DIGITS)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dbg_state (dbg_state),
        .result    (result),
        .cout      (cout)
`ifdef BCD_INPUT_CHECK_EN
        ,
        .bcd_err   (bcd_err)
`endif
    );

    // ---------------- DIGITS=1 instance ----------------
    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [3:0]  a1 = '0;
    logic [3:0]  b1 = '0;
    logic        sub1 = 1'b0;
    logic        cin1 = 1'b0;
    logic        out_valid1;
    logic        out_ready1 = 1'b0;
    state_t      dbg_state1;
    logic [3:0]  result1;
    logic        cout1;
`ifdef BCD_INPUT_CHECK_EN
    logic        bcd_err1;
`endif

    bcd_serial_addsub #(.DIGITS(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .sub       (sub1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .dbg_state (dbg_state1),
        .result    (result1),
        .cout      (cout1)
`ifdef BCD_INPUT_CHECK_EN
        ,
        .bcd_err   (bcd_err1)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] v = '0;
        int m = n;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return v;
    endfunction

    // Decimal add/subtract on whole numbers; result modulo 10^DIGITS.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic msub, input logic mcin,
                                  output logic [W-1:0] mres, output logic mcout);
        int x = bcd2int(ma);
        int y = bcd2int(mb);
        int d;
        if (msub) begin
            d     = x - y;
            mcout = (d >= 0);
            if (d < 0) d = d + MOD;
        end else begin
            d     = x + y + int'(mcin);
            mcout = (d >= MOD);
            d     = d % MOD;
        end
        mres = int2bcd(d);
    endfunction

    function automatic logic has_non_bcd(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // ---------------- driver: one full operation ----------------
    // Issues the operation, checks latency, holds the result for 'hold'
    // cycles of back-pressure (with a stray in_valid), then hands it off.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input logic tc, input int hold);
        logic [W-1:0] er;
        logic         ec;
        logic         bad;
        int           guard;
        int           lat;
        bad = has_non_bcd(ta) || has_non_bcd(tb);
        model(ta, tb, ts, tc, er, ec);
        exp_q.push_back(er);

        @(negedge clk);
        a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        chk({tag, "_accept_timeout"}, 32'(guard < 50), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = rand_bcd(); b = rand_bcd();

        // Accepting edge followed by DIGITS RUN edges: out_valid appears
        // after the DIGITS-th edge past acceptance (DIGITS+1 edges in all).
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency"}, 32'(lat), 32'(DIGITS));
        er = exp_q.pop_front();
        if (!bad) begin
            chk({tag, "_result"}, 32'(result), 32'(er));
            chk({tag, "_cout"}, 32'(cout), 32'(ec));
        end
`ifdef BCD_INPUT_CHECK_EN
        chk({tag, "_bcd_err"}, 32'(bcd_err), 32'(bad));
`endif

        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            if (!bad) begin
                chk({tag, "_hold_result"}, 32'(result), 32'(er));
                chk({tag, "_hold_cout"}, 32'(cout), 32'(ec));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_post_state"}, 32'(dbg_state), 32'(S_IDLE));
`ifdef BCD_INPUT_CHECK_EN
        chk({tag, "_post_bcd_err"}, 32'(bcd_err), 32'd0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
`ifdef BCD_INPUT_CHECK_EN
        chk("rst_bcd_err", 32'(bcd_err), 32'd0);
`endif
        rst_n = 1'b1;

        // Directed cases
        run_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0, 0);
        run_op("add_1234_5678_c", 16'h1234, 16'h5678, 1'b0, 1'b1, 0);
        run_op("sub_0456_0123", 16'h0456, 16'h0123, 1'b1, 1'b0, 0);
        run_op("sub_0123_0456", 16'h0123, 16'h0456, 1'b1, 1'b1, 0);
        run_op("sub_0000_0000", 16'h0000, 16'h0000, 1'b1, 1'b0, 0);
        run_op("backpressure", 16'h4821, 16'h3907, 1'b0, 1'b1, 3);

        // Reset during RUN while digit 2 is being processed
        @(negedge clk);
        a = 16'h8765; b = 16'h4321; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_state", 32'(dbg_state), 32'(S_IDLE));
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        run_op("after_rst", 16'h8765, 16'h4321, 1'b0, 1'b0, 1);

`ifdef BCD_INPUT_CHECK_EN
        run_op("err_00A5", 16'h00A5, 16'h0011, 1'b0, 1'b0, 1);
        run_op("err_clear", 16'h0042, 16'h0017, 1'b0, 1'b0, 0);
`endif

        // Randomised operations
        for (int n = 0; n < 20; n++) begin
            run_op($sformatf("rnd%0d", n), rand_bcd(), rand_bcd(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)));
        end

        // DIGITS=1: 9+9 -> 8 with carry, after a single RUN cycle
        @(negedge clk);
        a1 = 4'd9; b1 = 4'd9; sub1 = 1'b0; cin1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("d1_latency", 32'(lat), 32'd1);
        chk("d1_result", 32'(result1), 32'd8);
        chk("d1_cout", 32'(cout1), 32'd1);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        chk("d1_post_in_ready", 32'(in_ready1), 32'd1);

        // DIGITS=1 subtract with borrow: 3-7 -> 6, no-borrow flag clear
        @(negedge clk);
        a1 = 4'd3; b1 = 4'd7; sub1 = 1'b1; cin1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        @(posedge clk); #1;
        chk("d1_sub_valid", 32'(out_valid1), 32'd1);
        chk("d1_sub_result", 32'(result1), 32'd6);
        chk("d1_sub_cout", 32'(cout1), 32'd0);
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
